// File: rtl/zerogame_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zerogame_pkg
// Description : Shared types and constants for the zero-game host controller:
//               FSM state encoding, one-hot player codes, parameter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package zerogame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_JUDGE  = 3'd2,
    ST_SHOW   = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] P3 = 3'b100;

  localparam int SETTLE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF   = 4;
  localparam int WIN_HITS_DEF   = 2;

  // Caller rotation P1 -> P2 -> P3 -> P1 on a one-hot code.
  function automatic logic [2:0] next_player(input logic [2:0] cur);
    return {cur[1:0], cur[2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/zerogame_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zerogame_if
// Description : Player-side bus of the zero-game host: button/flag inputs and
//               turn, score and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface zerogame_if;

  logic       go;
  logic       same;
  logic [2:0] turn;
  logic       busy;
  logic       hit;
  logic [1:0] score1;
  logic [1:0] score2;
  logic [1:0] score3;
  logic [3:0] round_cnt;
  logic [2:0] winner;
  logic       game_over;

  // Game datapath / panel side.
  modport master (
    output go, same,
    input  turn, busy, hit, score1, score2, score3, round_cnt, winner, game_over
  );

  // Host controller side.
  modport slave (
    input  go, same,
    output turn, busy, hit, score1, score2, score3, round_cnt, winner, game_over
  );

endinterface
`default_nettype wire

// File: rtl/zerogame_rise_det.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zerogame_rise_det
// Description : Rising-edge detector. History resets to 1 so a level that is
//               already high when reset releases is not seen as an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module zerogame_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic r_in_q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk) begin
    if (reset) r_in_q <= 1'b1;
    else       r_in_q <= in;
  end

  assign rise = in & ~r_in_q;

endmodule
`default_nettype wire

// File: rtl/zerogame_host.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : zerogame_host
// Description : Turn/score controller for a three-player zero game. A go edge
//               starts a round; after settling, `same` is judged once, the
//               caller scores on a correct call, and the turn rotates after
//               the result hold. Reaching WIN_HITS ends the game.
// Revision    : 1.0 - initial release
// ============================================================================
module zerogame_host
  import zerogame_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int WIN_HITS   = WIN_HITS_DEF
) (
  input logic       clk,
  input logic       reset,
  zerogame_if.slave bus
);

  localparam int CNT_MAX = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [1:0]       WIN_LVL     = 2'(WIN_HITS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_turn;
  logic [2:0]       r_winner;
  logic [1:0]       r_score [3];
  logic [3:0]       r_round;
  logic             r_hit;

  logic             w_go_rise;
  logic [1:0]       w_cur_score;
  logic [1:0]       w_inc_score;
  logic             w_win;
  logic             w_judge_hit;
  logic             w_advance;
  logic             w_clear;

  zerogame_rise_det u_go_rise (
    .clk   (clk),
    .reset (reset),
    .in    (bus.go),
    .rise  (w_go_rise)
  );

  // Score of the current caller and whether one more hit wins the game.
  always_comb begin
    w_cur_score = r_score[0];
    if (r_turn[1])      w_cur_score = r_score[1];
    else if (r_turn[2]) w_cur_score = r_score[2];
    w_inc_score = w_cur_score + 2'd1;
    w_win       = (w_inc_score == WIN_LVL);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_judge_hit = 1'b0;
    w_advance   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_go_rise) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = ST_JUDGE;
      ST_JUDGE: begin
        w_judge_hit = bus.same;
        w_state_nxt = (bus.same && w_win) ? ST_OVER : ST_SHOW;
      end
      ST_SHOW: begin
        if (r_cnt == HOLD_LAST) begin
          w_advance   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OVER: begin
        if (w_go_rise) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Dwell counter for SETTLE and SHOW; restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset || (w_state_nxt != r_state))
      r_cnt <= '0;
    else if ((r_state == ST_SETTLE) || (r_state == ST_SHOW))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Scores, turn, round count, winner and hit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit    <= 1'b0;
      r_turn   <= P1;
      r_round  <= 4'd0;
      r_winner <= 3'b000;
      for (int i = 0; i < 3; i++) r_score[i] <= 2'd0;
    end else begin
      r_hit <= w_judge_hit;
      if (w_judge_hit) begin
        for (int i = 0; i < 3; i++) begin
          if (r_turn[i]) r_score[i] <= w_inc_score;
        end
        if (w_win) r_winner <= r_turn;
      end
      if (w_advance) begin
        r_turn  <= next_player(r_turn);
        r_round <= r_round + 4'd1;
      end
      if (w_clear) begin
        r_turn   <= P1;
        r_round  <= 4'd0;
        r_winner <= 3'b000;
        for (int i = 0; i < 3; i++) r_score[i] <= 2'd0;
      end
    end
  end

  assign bus.turn      = r_turn;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.hit       = r_hit;
  assign bus.score1    = r_score[0];
  assign bus.score2    = r_score[1];
  assign bus.score3    = r_score[2];
  assign bus.round_cnt = r_round;
  assign bus.winner    = r_winner;
  assign bus.game_over = (r_state == ST_OVER);

endmodule
`default_nettype wire

// File: doc/zerogame_host.md
ZEROGAME_HOST -- requirements
Module: zerogame_host

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, meaning cycles waited after round start before sampling `same`.
REQ-002 The block SHALL have parameter HOLD_CYC, default 4, meaning cycles the result is shown before the turn advances.
REQ-003 The block SHALL have parameter WIN_HITS, default 2 (range 1..3), meaning correct calls needed to win.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  clock.
REQ-006 Port: reset  input  1  synchronous active-high reset.
REQ-007 Port: go  input  1  round-start button level (already synchronized).
REQ-008 Port: same  input  1  caller-guess-equals-sum flag from the game datapath.
REQ-009 Port: turn  output  3  one-hot current caller (bit0=P1, bit1=P2, bit2=P3).
REQ-010 Port: busy  output  1  high whenever the state is not IDLE.
REQ-011 Port: hit  output  1  one-cycle pulse on a correct call.
REQ-012 Port: score1, score2, score3  output  2 each  per-player correct-call counts.
REQ-013 Port: round_cnt  output  4  completed rounds.
REQ-014 Port: winner  output  3  one-hot winning player; zero until the game ends.
REQ-015 Port: game_over  output  1  high in OVER.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, JUDGE, SHOW, OVER.
REQ-017 go_rise SHALL be defined as go=1 now and go=0 in the previous cycle; a held go SHALL NOT retrigger.
REQ-018 IDLE SHALL move to SETTLE on go_rise; go_rise SHALL be ignored in SETTLE, JUDGE and SHOW.
REQ-019 SETTLE SHALL last exactly SETTLE_CYC cycles, then move to JUDGE.
REQ-020 JUDGE SHALL last one cycle and sample `same` in that cycle only; `same` in any other state SHALL be ignored.
REQ-021 If `same`=1 in JUDGE, hit SHALL pulse in the next cycle and the score of the current caller SHALL increment by 1.
REQ-022 If the incremented score equals WIN_HITS, the FSM SHALL enter OVER, set winner=turn, and leave turn and round_cnt unchanged.
REQ-023 Otherwise JUDGE SHALL move to SHOW; SHOW SHALL last HOLD_CYC cycles.
REQ-024 On the SHOW exit, turn SHALL rotate P1->P2->P3->P1, round_cnt SHALL increment (15 wraps to 0), and the FSM SHALL return to IDLE.
REQ-025 Scores SHALL never exceed WIN_HITS.
REQ-026 OVER SHALL hold all outputs until reset, or until go_rise clears scores, winner and round_cnt, sets turn=P1 and returns to IDLE (not a new round).
REQ-027 Latency from go_rise to hit SHALL be SETTLE_CYC+2 cycles.
REQ-028 turn SHALL always be exactly one-hot.

Reset
REQ-029 Reset SHALL force state IDLE, turn=3'b001, busy=0, hit=0, score1..3=0, round_cnt=0, winner=0, game_over=0 and the go history register to 1.
REQ-030 Reset SHALL take priority over every other event in any state, including mid-SETTLE and mid-SHOW.
REQ-031 Reset SHALL suppress a pending hit pulse.
REQ-032 Because the go history register resets to 1, a go held high through reset SHALL NOT start a round.

Structure
REQ-033 Shared package zerogame_pkg SHALL hold the state encoding, one-hot player constants P1/P2/P3, and the parameter defaults.
REQ-034 The go edge detector SHALL be a separate sub-module zerogame_rise_det (clk, reset, in, rise).
REQ-035 Counters and the FSM SHALL live in zerogame_host.

Verification
REQ-036 Reset, then go pulse with same=0 -> hit never asserts; after 2+1+4 cycles turn=3'b010, round_cnt=1, busy=0.
REQ-037 same=1 held, three go pulses (defaults) -> score1=1 after round 1, score2=1 after round 2, score3=1 after round 3; round_cnt=3, turn=3'b001.
REQ-038 WIN_HITS=2, same=1, six rounds -> after round 4 score1=2, game_over=1, winner=3'b001, turn stays 3'b001; a further go_rise -> all scores 0, IDLE.
REQ-039 go held high 20 cycles -> exactly one round; same toggled outside JUDGE -> no hit.
REQ-040 Reset asserted in SHOW with score2=1 -> next cycle all outputs at reset values; go held across reset -> no round starts.
